button_conditioner: RTL
=======================

Name: button_conditioner

Overview:
- Upstream front end for the board top-level. Converts the five raw, bouncy push-button pins into clean single-cycle pulses that feed the BTNC/BTNU/BTND/BTNR/BTNL inputs of the game state machine.
- Per button: 2-flop synchroniser, debounce filter and press-edge detection.
- Optional auto-repeat on the four direction buttons.
- Output arbiter guarantees at most one pulse per cycle, so the move FSM never sees simultaneous buttons.

Parameters:
- DEBOUNCE_CYC, 488: consecutive stable samples required to accept a level change (~10 ms at 48.8 kHz).
- REPEAT_DELAY_CYC, 24400: hold time before the first auto-repeat pulse (~500 ms).
- REPEAT_RATE_CYC, 4880: interval between subsequent auto-repeat pulses (~100 ms).

Ports:
- clk, input, 1: system clock, 48.8 kHz.
- reset, input, 1: synchronous, active-high.
- BTNC_in, BTNU_in, BTND_in, BTNR_in, BTNL_in: input, 1 each; raw asynchronous pins, active-high.
- BTNC, BTNU, BTND, BTNR, BTNL: output, 1 each; single-cycle press pulses, registered.
- held, output, 5: debounced levels in order {C,U,D,R,L}, registered.
- pending, output, 5: accepted presses awaiting arbitration, same order.

Behaviour:
- Clock and reset: one clock (clk); reset is synchronous and active-high.
- Reset values: all pulse outputs 0; held=0; pending=0; synchronisers 0; every filter in IDLE with counters 0.
- Synchroniser: 2 flops per pin. Filter input is sync[1], so there are 2 cycles of sync latency.
- Filter FSM (per button), states IDLE, PRESS_CHK, HELD, REL_CHK:
  - IDLE: sync=1 -> PRESS_CHK, cnt=1.
  - PRESS_CHK: sync=0 -> IDLE, cnt=0. Otherwise cnt++. When cnt reaches DEBOUNCE_CYC -> HELD, held bit=1, set pending bit, cnt=0.
  - HELD: sync=0 -> REL_CHK, cnt=1.
  - REL_CHK: sync=1 -> HELD, cnt=0 (glitch rejected; no new press). When cnt reaches DEBOUNCE_CYC -> IDLE, held bit=0.
- Counter width: $clog2 of the largest parameter + 1. Counters saturate and never wrap.
- Latency, press to pulse: 2 (sync) + DEBOUNCE_CYC + 1 (arbiter register) cycles when no other request is pending.
- Arbiter (each cycle):
  - Fixed priority C > U > D > R > L among pending bits.
  - Winner: its pulse output is 1 next cycle and its pending bit clears.
  - Losers stay pending and are issued on later cycles in priority order.
  - No pending press is ever dropped.
  - A new press of a button whose pending bit is already set is merged (counted once).
- Simultaneous set and clear of the same pending bit in one cycle: set wins, bit stays 1.
- Release before issue: a pending bit stays set even if the button is released first; the press still counts.
- Mid-operation reset: all state clears in that cycle. Pending presses are discarded. No pulse in the cycle after reset is asserted.

Optional Feature:
- Macro: BUTTON_AUTO_REPEAT_EN.
- Defined: U/D/R/L each have a repeat counter that runs while the button is in HELD. It sets the pending bit at REPEAT_DELAY_CYC, then every REPEAT_RATE_CYC after that. The counter clears on leaving HELD. BTNC never repeats.
- Undefined: one pulse per press. No repeat counters are synthesised.

Decomposition:
- Package button_pkg holds:
  - DEBOUNCE_CYC, REPEAT_DELAY_CYC, REPEAT_RATE_CYC defaults;
  - filter state encoding (IDLE=2'd0, PRESS_CHK=2'd1, HELD=2'd2, REL_CHK=2'd3);
  - button index constants (C=4, U=3, D=2, R=1, L=0).
- Sub-module btn_filter holds the synchroniser, filter FSM and optional repeat counter. It is instantiated 5 times.
- The top holds the pending register and the priority arbiter.

Test Plan:
- Clean press: BTNU_in held high 1000 cycles -> exactly one BTNU pulse at cycle 2+488+1=491; held[3]=1 from cycle 490 until 2+488 cycles after release.
- Bounce: BTNC_in toggles every 50 cycles for 400 cycles, then stays high -> no pulse during bounce; one BTNC pulse 491 cycles after the last rising edge; a 100-cycle low glitch while held produces no pulse.
- Simultaneous: BTNL_in and BTNU_in rise on the same cycle and are held -> BTNU pulse on cycle N, BTNL pulse on N+1, never both together; pending goes 01001 -> 00001 -> 00000.
- Auto-repeat (macro on): BTNR_in held 40000 cycles -> pulses at ~491, ~491+24400, then every 4880 cycles; BTNC held the same time gives 1 pulse. Macro off: 1 pulse each.
- Reset mid-operation: reset asserted for 1 cycle while BTND is pending -> no BTND pulse; all outputs 0 the cycle after; a fresh press is accepted normally afterwards.

Source files
------------

// File: rtl/button_pkg.sv
// Shared constants, filter state encoding and helpers for the button conditioner.
package button_pkg;

  localparam int DEBOUNCE_CYC_DEF     = 488;
  localparam int REPEAT_DELAY_CYC_DEF = 24400;
  localparam int REPEAT_RATE_CYC_DEF  = 4880;

  localparam int NUM_BTN = 5;

  // Bit positions inside the {C,U,D,R,L} vectors; higher index = higher priority.
  localparam int IDX_C = 4;
  localparam int IDX_U = 3;
  localparam int IDX_D = 2;
  localparam int IDX_R = 1;
  localparam int IDX_L = 0;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    PRESS_CHK = 2'd1,
    HELD      = 2'd2,
    REL_CHK   = 2'd3
  } filter_state_e;

  function automatic int cnt_width(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return $clog2(m) + 1;
  endfunction

  // One-hot of the highest set request bit, or zero when nothing is requested.
  function automatic logic [NUM_BTN-1:0] pick_highest(input logic [NUM_BTN-1:0] req);
    logic [NUM_BTN-1:0] g;
    g = '0;
    for (int i = 0; i < NUM_BTN; i++) begin
      if (req[i]) begin
        g    = '0;
        g[i] = 1'b1;
      end
    end
    return g;
  endfunction

endpackage

// File: rtl/button_conditioner_if.sv
// Raw button pins in, conditioned pulses and status out; slave side is the conditioner.
interface button_conditioner_if;
  logic       BTNC_in, BTNU_in, BTND_in, BTNR_in, BTNL_in;
  logic       BTNC, BTNU, BTND, BTNR, BTNL;
  logic [4:0] held;
  logic [4:0] pending;

  modport master (
    output BTNC_in, BTNU_in, BTND_in, BTNR_in, BTNL_in,
    input  BTNC, BTNU, BTND, BTNR, BTNL, held, pending
  );

  modport slave (
    input  BTNC_in, BTNU_in, BTND_in, BTNR_in, BTNL_in,
    output BTNC, BTNU, BTND, BTNR, BTNL, held, pending
  );
endinterface

// File: rtl/btn_filter.sv
// Per-button 2-flop synchroniser, debounce FSM and (with BUTTON_AUTO_REPEAT_EN) hold-repeat counter.
// press is a one-cycle request to set the button's pending bit.
module btn_filter
  import button_pkg::*;
#(
  parameter int DEBOUNCE_CYC     = DEBOUNCE_CYC_DEF,
  parameter int REPEAT_DELAY_CYC = REPEAT_DELAY_CYC_DEF,
  parameter int REPEAT_RATE_CYC  = REPEAT_RATE_CYC_DEF
`ifdef BUTTON_AUTO_REPEAT_EN
  , parameter bit REPEAT_EN      = 1'b1
`endif
) (
  input  logic clk,
  input  logic reset,
  input  logic pin_in,
  output logic held,
  output logic press
);

  localparam int             CNT_W    = cnt_width(DEBOUNCE_CYC, REPEAT_DELAY_CYC, REPEAT_RATE_CYC);
  localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_CYC - 1);

  logic [1:0]       sync_q, sync_d;
  filter_state_e    state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic             held_q, held_d;
  logic             accept;
  logic             level;

  assign level   = sync_q[1];
  assign cnt_inc = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    sync_d  = {sync_q[0], pin_in};
    state_d = state_q;
    cnt_d   = cnt_q;
    held_d  = held_q;
    accept  = 1'b0;
    case (state_q)
      IDLE: if (level) begin
        state_d = PRESS_CHK;
        cnt_d   = CNT_W'(1);
      end
      PRESS_CHK: begin
        if (!level) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q >= DEB_LAST) begin
          state_d = HELD;
          held_d  = 1'b1;
          accept  = 1'b1;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      HELD: if (!level) begin
        state_d = REL_CHK;
        cnt_d   = CNT_W'(1);
      end
      REL_CHK: begin
        if (level) begin
          state_d = HELD;
          cnt_d   = '0;
        end else if (cnt_q >= DEB_LAST) begin
          state_d = IDLE;
          held_d  = 1'b0;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
        held_d  = 1'b0;
      end
    endcase
  end

  // NOTE: state flops use non-blocking assignment so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q  <= '0;
      state_q <= IDLE;
      cnt_q   <= '0;
      held_q  <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      held_q  <= held_d;
    end
  end

  assign held = held_q;

`ifdef BUTTON_AUTO_REPEAT_EN
  logic rpt_fire;

  if (REPEAT_EN) begin : g_rpt
    localparam logic [CNT_W-1:0] RPT_LAST   = CNT_W'(REPEAT_DELAY_CYC - 1);
    localparam logic [CNT_W-1:0] RPT_RELOAD = CNT_W'(REPEAT_DELAY_CYC - REPEAT_RATE_CYC);

    logic [CNT_W-1:0] rpt_q, rpt_d;

    // Reloading to DELAY-RATE after a fire spaces later fires RATE cycles apart.
    assign rpt_fire = (state_q == HELD) && (rpt_q == RPT_LAST);

    always_comb begin
      rpt_d = '0;
      if (state_q == HELD) rpt_d = rpt_fire ? RPT_RELOAD : rpt_q + 1'b1;
    end

    always_ff @(posedge clk) begin
      if (reset) rpt_q <= '0;
      else       rpt_q <= rpt_d;
    end
  end else begin : g_no_rpt
    assign rpt_fire = 1'b0;
  end

  assign press = accept | rpt_fire;
`else
  assign press = accept;
`endif

endmodule

// File: rtl/button_conditioner.sv
// Five debounced buttons feeding a pending register and fixed-priority (C>U>D>R>L) one-hot pulse arbiter.
// Optional auto-repeat on U/D/R/L is enabled by defining BUTTON_AUTO_REPEAT_EN.
module button_conditioner
  import button_pkg::*;
#(
  parameter int DEBOUNCE_CYC     = DEBOUNCE_CYC_DEF,
  parameter int REPEAT_DELAY_CYC = REPEAT_DELAY_CYC_DEF,
  parameter int REPEAT_RATE_CYC  = REPEAT_RATE_CYC_DEF
) (
  input logic                 clk,
  input logic                 reset,
  button_conditioner_if.slave bus
);

  logic [NUM_BTN-1:0] pin_v, held_v, press_v, grant;
  logic [NUM_BTN-1:0] pending_q, pending_d;
  logic [NUM_BTN-1:0] pulse_q, pulse_d;

  assign pin_v = {bus.BTNC_in, bus.BTNU_in, bus.BTND_in, bus.BTNR_in, bus.BTNL_in};

  for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn
    btn_filter #(
      .DEBOUNCE_CYC     (DEBOUNCE_CYC),
      .REPEAT_DELAY_CYC (REPEAT_DELAY_CYC),
      .REPEAT_RATE_CYC  (REPEAT_RATE_CYC)
`ifdef BUTTON_AUTO_REPEAT_EN
      , .REPEAT_EN      (i != IDX_C)
`endif
    ) u_filter (
      .clk    (clk),
      .reset  (reset),
      .pin_in (pin_v[i]),
      .held   (held_v[i]),
      .press  (press_v[i])
    );
  end

  // A press landing on the bit being granted this cycle survives: set wins over clear.
  always_comb begin
    grant     = pick_highest(pending_q);
    pulse_d   = grant;
    pending_d = (pending_q & ~grant) | press_v;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pending_q <= '0;
      pulse_q   <= '0;
    end else begin
      pending_q <= pending_d;
      pulse_q   <= pulse_d;
    end
  end

  assign bus.BTNC    = pulse_q[IDX_C];
  assign bus.BTNU    = pulse_q[IDX_U];
  assign bus.BTND    = pulse_q[IDX_D];
  assign bus.BTNR    = pulse_q[IDX_R];
  assign bus.BTNL    = pulse_q[IDX_L];
  assign bus.held    = held_v;
  assign bus.pending = pending_q;

endmodule
